// File: rtl/tlb_mmu_pkg.sv
// Shared definitions for the TLB/MMU: EntryLo layout, segment bounds, entry record.
// Latency: none (types, constants and pure helper functions only).
// Backpressure: not applicable.
package tlb_mmu_pkg;

  // EntryLo field positions
  localparam int LO_PFN_LSB = 6;
  localparam int PFN_W      = 20;
  localparam int LO_C_LSB   = 3;
  localparam int C_W        = 3;
  localparam int LO_D       = 2;
  localparam int LO_V       = 1;
  localparam int LO_G       = 0;

  localparam int VPN2_W     = 19;
  // Widest ASID the entry record can hold; narrower ASIDs are zero-extended.
  localparam int ASID_MAX_W = 16;

  // Unmapped segments: [KSEG0_BASE, KSEG1_BASE) cached window, [KSEG1_BASE, KSEG2_BASE) uncached
  localparam logic [31:0] KSEG0_BASE = 32'h8000_0000;
  localparam logic [31:0] KSEG1_BASE = 32'hA000_0000;
  localparam logic [31:0] KSEG2_BASE = 32'hC000_0000;

  // CP0 Index register: probe-failure bit
  localparam int IDX_P_BIT = 31;

  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_FLUSH = 1'b1
  } fl_state_e;

  typedef struct packed {
    logic [PFN_W-1:0] pfn;
    logic [C_W-1:0]   c;
    logic             d;
    logic             v;
  } tlb_page_t;

  typedef struct packed {
    logic [VPN2_W-1:0]     vpn2;
    logic [ASID_MAX_W-1:0] asid;
    logic                  g;
    tlb_page_t             p0;
    tlb_page_t             p1;
  } tlb_entry_t;

  localparam int PAGE_W  = PFN_W + C_W + 2;
  localparam int ENTRY_W = VPN2_W + ASID_MAX_W + 1 + 2 * PAGE_W;

  // Extract one page's fields from EntryLo bits [25:1] (G is handled per entry)
  function automatic tlb_page_t lo_to_page(input logic [25:1] f);
    tlb_page_t p;
    p.pfn = f[LO_PFN_LSB +: PFN_W];
    p.c   = f[LO_C_LSB +: C_W];
    p.d   = f[LO_D];
    p.v   = f[LO_V];
    return p;
  endfunction

  // Rebuild an EntryLo word; unused bits read as zero
  function automatic logic [31:0] page_to_lo(input tlb_page_t p, input logic g);
    return {6'b0, p.pfn, p.c, p.d, p.v, g};
  endfunction

endpackage

// File: rtl/tlb_match.sv
// Priority matcher: finds the lowest-index entry matching VPN2 and ASID/G, returns its page.
// Latency: purely combinational.
// Backpressure: none; evaluated every cycle.
module tlb_match
  import tlb_mmu_pkg::*;
#(
  parameter int ENTRIES = 16,
  parameter int IDX_W   = 4,
  parameter int ASID_W  = 8
) (
  input  logic [19:0]              vpn_i,   // vaddr[31:12]; bit 0 selects the odd page
  input  logic [ASID_W-1:0]        asid_i,
  input  logic [ENTRIES*ENTRY_W-1:0] arr_i,
  output logic                     hit_o,
  output logic [IDX_W-1:0]         idx_o,
  output logic [PFN_W-1:0]         pfn_o,
  output logic [C_W-1:0]           c_o,
  output logic                     d_o,
  output logic                     v_o
);

  tlb_entry_t e;
  tlb_page_t  pg;

  // Scan from the top down so the lowest matching index is the last one to win
  always_comb begin
    e     = '0;
    pg    = '0;
    hit_o = 1'b0;
    idx_o = '0;
    for (int i = ENTRIES - 1; i >= 0; i--) begin
      e = arr_i[i*ENTRY_W +: ENTRY_W];
      if (e.vpn2 == vpn_i[19:1] && (e.g || e.asid == ASID_MAX_W'(asid_i))) begin
        hit_o = 1'b1;
        idx_o = IDX_W'(i);
        pg    = vpn_i[0] ? e.p1 : e.p0;
      end
    end
    pfn_o = pg.pfn;
    c_o   = pg.c;
    d_o   = pg.d;
    v_o   = pg.v;
  end

endmodule

// File: rtl/tlb_mmu.sv
// Multi-channel MIPS-style TLB with probe, indexed read, fault flags and a sequential flush.
// Latency: lookup, probe and read results are registered, one cycle after the request.
// Backpressure: none; writes arriving while busy_o is high are dropped, lookups always answer.
module tlb_mmu
  import tlb_mmu_pkg::*;
#(
  parameter int ENTRIES = 16,
  parameter int IDX_W   = 4,
  parameter int NCH     = 2,
  parameter int ASID_W  = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [ASID_W-1:0] asid_i,
  input  logic              wr_en_i,
  input  logic [IDX_W-1:0]  wr_idx_i,
  input  logic [31:0]       wr_hi_i,
  input  logic [31:0]       wr_lo0_i,
  input  logic [31:0]       wr_lo1_i,
  input  logic              flush_i,
  output logic              busy_o,
  input  logic [IDX_W-1:0]  rd_idx_i,
  output logic [31:0]       rd_hi_o,
  output logic [31:0]       rd_lo0_o,
  output logic [31:0]       rd_lo1_o,
  input  logic              probe_en_i,
  input  logic [31:0]       probe_hi_i,
  output logic              probe_valid_o,
  output logic [31:0]       probe_index_o,
  input  logic [NCH-1:0]    lk_req_i,
  input  logic [NCH*32-1:0] lk_vaddr_i,
  input  logic [NCH-1:0]    lk_store_i,
  output logic [NCH-1:0]    lk_valid_o,
  output logic [NCH*32-1:0] lk_paddr_o,
  output logic [NCH-1:0]    lk_mapped_o,
  output logic [NCH-1:0]    lk_refill_o,
  output logic [NCH-1:0]    lk_invalid_o,
  output logic [NCH-1:0]    lk_mod_o
);

  fl_state_e               state_q;
  logic [IDX_W-1:0]        fl_cnt_q;
  tlb_entry_t              ent_q [ENTRIES];
  logic [ENTRIES*ENTRY_W-1:0] arr_flat;
  tlb_entry_t              wr_ent;
  tlb_entry_t              rd_ent;
  logic                    busy;
  logic                    wr_fire;

  assign busy    = (state_q == ST_FLUSH);
  assign busy_o  = busy;
  // Flush and reset both take priority over a write
  assign wr_fire = wr_en_i && !busy && !flush_i && rst;

  for (genvar i = 0; i < ENTRIES; i++) begin : g_flat
    assign arr_flat[i*ENTRY_W +: ENTRY_W] = ent_q[i];
  end

  // Flush sequencer: reset or flush_i walks fl_cnt over every entry once
  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q  <= ST_FLUSH;
      fl_cnt_q <= '0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (flush_i) begin
            state_q  <= ST_FLUSH;
            fl_cnt_q <= '0;
          end
        end
        ST_FLUSH: begin
          fl_cnt_q <= fl_cnt_q + 1'b1;
          if (fl_cnt_q == IDX_W'(ENTRIES - 1)) state_q <= ST_IDLE;
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  // Assemble the record to be written from CP0's EntryHi/EntryLo words
  always_comb begin
    wr_ent      = '0;
    wr_ent.vpn2 = wr_hi_i[31:13];
    wr_ent.asid = ASID_MAX_W'(wr_hi_i[ASID_W-1:0]);
    wr_ent.g    = wr_lo0_i[LO_G] & wr_lo1_i[LO_G];
    wr_ent.p0   = lo_to_page(wr_lo0_i[25:1]);
    wr_ent.p1   = lo_to_page(wr_lo1_i[25:1]);
  end

  // Entry array: CP0 writes when idle, flush clears V0/V1/G of one entry per cycle
  always_ff @(posedge clk) begin
    if (wr_fire) ent_q[wr_idx_i] <= wr_ent;
    if (busy) begin
      ent_q[fl_cnt_q].p0.v <= 1'b0;
      ent_q[fl_cnt_q].p1.v <= 1'b0;
      ent_q[fl_cnt_q].g    <= 1'b0;
    end
  end

  // ---------------- lookup channels ----------------
  logic [NCH-1:0]       m_hit, m_d, m_v;
  logic [NCH*IDX_W-1:0] m_idx;
  logic [NCH*PFN_W-1:0] m_pfn;
  logic [NCH*C_W-1:0]   m_c;

  for (genvar c = 0; c < NCH; c++) begin : g_ch
    tlb_match #(.ENTRIES(ENTRIES), .IDX_W(IDX_W), .ASID_W(ASID_W)) u_match (
      .vpn_i  (lk_vaddr_i[32*c+12 +: 20]),
      .asid_i (asid_i),
      .arr_i  (arr_flat),
      .hit_o  (m_hit[c]),
      .idx_o  (m_idx[c*IDX_W +: IDX_W]),
      .pfn_o  (m_pfn[c*PFN_W +: PFN_W]),
      .c_o    (m_c[c*C_W +: C_W]),
      .d_o    (m_d[c]),
      .v_o    (m_v[c])
    );
  end

  logic [NCH*32-1:0] paddr_d;
  logic [NCH-1:0]    mapped_d, refill_d, invalid_d, mod_d;
  logic [31:0]       va;

  // Segment decode and fault classification; idle channels produce an all-zero result
  always_comb begin
    paddr_d   = '0;
    mapped_d  = '0;
    refill_d  = '0;
    invalid_d = '0;
    mod_d     = '0;
    va        = '0;
    for (int c = 0; c < NCH; c++) begin
      va = lk_vaddr_i[32*c +: 32];
      if (!lk_req_i[c]) begin
        paddr_d[32*c +: 32] = '0;
      end else if (va >= KSEG0_BASE && va < KSEG1_BASE) begin
        paddr_d[32*c +: 32] = {1'b0, va[30:0]};
      end else if (va >= KSEG1_BASE && va < KSEG2_BASE) begin
        paddr_d[32*c +: 32] = {3'b0, va[28:0]};
      end else begin
        mapped_d[c] = 1'b1;
        if (!m_hit[c]) begin
          refill_d[c] = 1'b1;
        end else if (!m_v[c]) begin
          invalid_d[c] = 1'b1;
        end else begin
          paddr_d[32*c +: 32] = {m_pfn[c*PFN_W +: PFN_W], va[11:0]};
          mod_d[c]            = lk_store_i[c] & ~m_d[c];
        end
      end
    end
  end

  // Lookup result registers
  always_ff @(posedge clk) begin
    if (!rst) begin
      lk_valid_o   <= '0;
      lk_paddr_o   <= '0;
      lk_mapped_o  <= '0;
      lk_refill_o  <= '0;
      lk_invalid_o <= '0;
      lk_mod_o     <= '0;
    end else begin
      lk_valid_o   <= lk_req_i;
      lk_paddr_o   <= paddr_d;
      lk_mapped_o  <= mapped_d;
      lk_refill_o  <= refill_d;
      lk_invalid_o <= invalid_d;
      lk_mod_o     <= mod_d;
    end
  end

  // ---------------- probe (TLBP) ----------------
  logic             pr_hit, pr_d, pr_v;
  logic [IDX_W-1:0] pr_idx;
  logic [PFN_W-1:0] pr_pfn;
  logic [C_W-1:0]   pr_c;
  logic [31:0]      pr_index_d;

  tlb_match #(.ENTRIES(ENTRIES), .IDX_W(IDX_W), .ASID_W(ASID_W)) u_probe (
    .vpn_i  (probe_hi_i[31:12]),
    .asid_i (probe_hi_i[ASID_W-1:0]),
    .arr_i  (arr_flat),
    .hit_o  (pr_hit),
    .idx_o  (pr_idx),
    .pfn_o  (pr_pfn),
    .c_o    (pr_c),
    .d_o    (pr_d),
    .v_o    (pr_v)
  );

  // Format the probe result as a CP0 Index word
  always_comb begin
    pr_index_d = '0;
    if (pr_hit) pr_index_d[IDX_W-1:0] = pr_idx;
    else        pr_index_d[IDX_P_BIT] = 1'b1;
  end

  // Probe result registers; index holds its last value between probes
  always_ff @(posedge clk) begin
    if (!rst) begin
      probe_valid_o <= 1'b0;
      probe_index_o <= 32'h8000_0000;
    end else begin
      probe_valid_o <= probe_en_i;
      if (probe_en_i) probe_index_o <= pr_index_d;
    end
  end

  // ---------------- indexed read (TLBR) ----------------
  assign rd_ent = ent_q[rd_idx_i];

  // Read-back registers, refreshed every cycle from rd_idx_i
  always_ff @(posedge clk) begin
    if (!rst) begin
      rd_hi_o  <= '0;
      rd_lo0_o <= '0;
      rd_lo1_o <= '0;
    end else begin
      rd_hi_o  <= {rd_ent.vpn2, 13'b0} | 32'(rd_ent.asid[ASID_W-1:0]);
      rd_lo0_o <= page_to_lo(rd_ent.p0, rd_ent.g);
      rd_lo1_o <= page_to_lo(rd_ent.p1, rd_ent.g);
    end
  end

  // Bits the datapath intentionally ignores (reserved EntryHi/EntryLo bits, probe page data)
  logic unused_ok;
  assign unused_ok = ^{wr_hi_i, wr_lo0_i, wr_lo1_i, probe_hi_i, m_idx, m_c,
                       pr_pfn, pr_c, pr_d, pr_v};

endmodule
